// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, owner codes, access-size encodings
// and the fetch line-base helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LSB  = 2'd2
    } arb_owner_e;

    localparam logic [2:0] PREC_B  = 3'b000;
    localparam logic [2:0] PREC_H  = 3'b001;
    localparam logic [2:0] PREC_W  = 3'b010;
    localparam logic [2:0] PREC_BS = 3'b100;
    localparam logic [2:0] PREC_HS = 3'b101;

    localparam int STARVE_MAX_DEFAULT = 4;

    // Fetches always move whole 64-byte lines.
    function automatic logic [31:0] line_base(input logic [31:0] pc);
        return {pc[31:6], 6'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, LSB and mem_ctrl signals around the arbiter. Store data towards mem_ctrl
// is mc_lsb_wdata; mc_lsb_data carries load data back.
interface mem_arbiter_if;
    logic        rdy;
    logic        rollback;

    logic        if_req;
    logic [31:0] if_pc;
    logic        if_done;

    logic        lsb_req;
    logic        lsb_ls;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_data;
    logic [2:0]  lsb_precise;
    logic [3:0]  lsb_rob;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [3:0]  lsb_done_rob;

    logic        mc_inst_config;
    logic [31:0] mc_inst_pc;
    logic        mc_inst_done;

    logic        mc_lsb_config;
    logic        mc_lsb_ls;
    logic [31:0] mc_lsb_addr;
    logic [31:0] mc_lsb_wdata;
    logic [2:0]  mc_lsb_precise;
    logic [3:0]  mc_lsb_rob;
    logic        mc_lsb_done;
    logic [31:0] mc_lsb_data;

    // The arbiter itself.
    modport slave (
        input  rdy, rollback,
        input  if_req, if_pc, lsb_req, lsb_ls, lsb_addr, lsb_data, lsb_precise, lsb_rob,
        input  mc_inst_done, mc_lsb_done, mc_lsb_data,
        output if_done, lsb_done, lsb_rdata, lsb_done_rob,
        output mc_inst_config, mc_inst_pc,
        output mc_lsb_config, mc_lsb_ls, mc_lsb_addr, mc_lsb_wdata, mc_lsb_precise, mc_lsb_rob
    );

    // Requesters plus mem_ctrl.
    modport master (
        output rdy, rollback,
        output if_req, if_pc, lsb_req, lsb_ls, lsb_addr, lsb_data, lsb_precise, lsb_rob,
        output mc_inst_done, mc_lsb_done, mc_lsb_data,
        input  if_done, lsb_done, lsb_rdata, lsb_done_rob,
        input  mc_inst_config, mc_inst_pc,
        input  mc_lsb_config, mc_lsb_ls, mc_lsb_addr, mc_lsb_wdata, mc_lsb_precise, mc_lsb_rob
    );
endinterface

// File: rtl/arb_prio_sel.sv
// Winner select between fetch and LSB, with the anti-starvation counter that forces an
// LSB win after STARVE_MAX consecutive fetch grants taken while the LSB was waiting.
module arb_prio_sel #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant,
    input  logic if_req,
    input  logic lsb_req,
    output logic lsb_wins
);

    localparam int              CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    assign lsb_wins = lsb_req && (!if_req || (starve_cnt == CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (lsb_wins || !lsb_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port mem_ctrl between fetch line fills and LSB accesses.
// Define ARB_PERF_EN to add grant and wait-cycle performance counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]  perf_if_grants,
    output logic [31:0]  perf_lsb_grants,
    output logic [31:0]  perf_wait_cycles
`endif
);

    arb_state_e  state, state_nxt;
    arb_owner_e  owner;
    logic        grant, lsb_wins, load_abort;
    logic        inst_config, lsb_config, inst_fin, lsb_fin;
    logic        if_done_q, lsb_done_q;
    logic [31:0] lsb_rdata_q;
    logic [3:0]  lsb_done_rob_q;
    logic [31:0] inst_pc_q, lsb_addr_q, lsb_wdata_q;
    logic        lsb_ls_q;
    logic [2:0]  lsb_precise_q;
    logic [3:0]  lsb_rob_q;

    arb_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio_sel (
        .clk      (clk),
        .rst      (rst),
        .grant    (grant),
        .if_req   (bus.if_req),
        .lsb_req  (bus.lsb_req),
        .lsb_wins (lsb_wins)
    );

    // Only a speculative load is dropped on rollback; stores and fetches run to completion.
    assign load_abort = bus.rollback && (owner == OWN_LSB) && lsb_ls_q;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        state_nxt   = state;
        grant       = 1'b0;
        inst_config = 1'b0;
        lsb_config  = 1'b0;
        inst_fin    = 1'b0;
        lsb_fin     = 1'b0;
        if (bus.rdy) begin
            case (state)
                ST_IDLE: begin
                    if (!bus.rollback && (bus.if_req || bus.lsb_req)) begin
                        grant     = 1'b1;
                        state_nxt = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    inst_config = !load_abort && (owner == OWN_IF);
                    lsb_config  = !load_abort && (owner == OWN_LSB);
                    state_nxt   = load_abort ? ST_GAP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (load_abort) begin
                        state_nxt = ST_GAP;
                    end else if ((owner == OWN_IF) && bus.mc_inst_done) begin
                        inst_fin  = 1'b1;
                        state_nxt = ST_GAP;
                    end else if ((owner == OWN_LSB) && bus.mc_lsb_done) begin
                        lsb_fin   = 1'b1;
                        state_nxt = ST_GAP;
                    end
                end
                ST_GAP:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so each one samples pre-edge values.
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner          <= OWN_NONE;
            if_done_q      <= 1'b0;
            lsb_done_q     <= 1'b0;
            lsb_rdata_q    <= '0;
            lsb_done_rob_q <= '0;
            inst_pc_q      <= '0;
            lsb_ls_q       <= 1'b0;
            lsb_addr_q     <= '0;
            lsb_wdata_q    <= '0;
            lsb_precise_q  <= '0;
            lsb_rob_q      <= '0;
        end else if (bus.rdy) begin
            if_done_q  <= inst_fin;
            lsb_done_q <= lsb_fin;
            if (grant) begin
                if (lsb_wins) begin
                    owner         <= OWN_LSB;
                    lsb_ls_q      <= bus.lsb_ls;
                    lsb_addr_q    <= bus.lsb_addr;
                    lsb_wdata_q   <= bus.lsb_data;
                    lsb_precise_q <= bus.lsb_precise;
                    lsb_rob_q     <= bus.lsb_rob;
                end else begin
                    owner     <= OWN_IF;
                    inst_pc_q <= line_base(bus.if_pc);
                end
            end else if (state == ST_GAP) begin
                owner <= OWN_NONE;
            end
            if (lsb_fin) begin
                lsb_rdata_q    <= bus.mc_lsb_data;
                lsb_done_rob_q <= lsb_rob_q;
            end
        end
    end

    // Done pulses are held through rdy=0 and show on the first ready cycle.
    assign bus.if_done        = if_done_q && bus.rdy;
    assign bus.lsb_done       = lsb_done_q && bus.rdy;
    assign bus.lsb_rdata      = lsb_rdata_q;
    assign bus.lsb_done_rob   = lsb_done_rob_q;
    assign bus.mc_inst_config = inst_config;
    assign bus.mc_inst_pc     = inst_pc_q;
    assign bus.mc_lsb_config  = lsb_config;
    assign bus.mc_lsb_ls      = lsb_ls_q;
    assign bus.mc_lsb_addr    = lsb_addr_q;
    assign bus.mc_lsb_wdata   = lsb_wdata_q;
    assign bus.mc_lsb_precise = lsb_precise_q;
    assign bus.mc_lsb_rob     = lsb_rob_q;

`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_grants   <= '0;
            perf_lsb_grants  <= '0;
            perf_wait_cycles <= '0;
        end else if (bus.rdy) begin
            if (grant && !lsb_wins) perf_if_grants  <= perf_if_grants + 32'd1;
            if (grant && lsb_wins)  perf_lsb_grants <= perf_lsb_grants + 32'd1;
            if (state == ST_WAIT)   perf_wait_cycles <= perf_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed corner cases then randomized traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    mem_arbiter_if bus ();

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_lsb_grants, perf_wait_cycles;
`endif

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_PERF_EN
        ,
        .perf_if_grants   (perf_if_grants),
        .perf_lsb_grants  (perf_lsb_grants),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int          starve = 0;
    int          g_if   = 0;
    int          g_lsb  = 0;
    logic [31:0] m_pc, m_addr, m_wdata;
    logic        m_ls;
    logic [2:0]  m_prec;
    logic [3:0]  m_rob;
    logic [2:0]  precs [5] = '{PREC_B, PREC_H, PREC_W, PREC_BS, PREC_HS};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fetch wins unless the LSB has waited through STARVE_MAX fetch grants.
    function automatic bit grant_model(input bit ifr, input bit lr);
        bit w;
        w = lr && (!ifr || (starve == STARVE_MAX));
        if (w || !lr)                 starve = 0;
        else if (starve < STARVE_MAX) starve++;
        if (w) g_lsb++;
        else   g_if++;
        return w;
    endfunction

    task automatic set_lsb(input logic ls, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] prec, input logic [3:0] rob);
        m_ls = ls; m_addr = addr; m_wdata = data; m_prec = prec; m_rob = rob;
        bus.lsb_ls = ls; bus.lsb_addr = addr; bus.lsb_data = data;
        bus.lsb_precise = prec; bus.lsb_rob = rob; bus.lsb_req = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_done"},   32'(bus.if_done), 32'd0);
        check({tag, "_lsb_done"},  32'(bus.lsb_done), 32'd0);
        check({tag, "_inst_cfg"},  32'(bus.mc_inst_config), 32'd0);
        check({tag, "_lsb_cfg"},   32'(bus.mc_lsb_config), 32'd0);
        check({tag, "_rdata"},     bus.lsb_rdata, 32'd0);
        check({tag, "_done_rob"},  32'(bus.lsb_done_rob), 32'd0);
        check({tag, "_inst_pc"},   bus.mc_inst_pc, 32'd0);
        check({tag, "_mc_ls"},     32'(bus.mc_lsb_ls), 32'd0);
        check({tag, "_mc_addr"},   bus.mc_lsb_addr, 32'd0);
        check({tag, "_mc_wdata"},  bus.mc_lsb_wdata, 32'd0);
        check({tag, "_mc_prec"},   32'(bus.mc_lsb_precise), 32'd0);
        check({tag, "_mc_rob"},    32'(bus.mc_lsb_rob), 32'd0);
`ifdef ARB_PERF_EN
        check({tag, "_perf_if"},   perf_if_grants, 32'd0);
        check({tag, "_perf_lsb"},  perf_lsb_grants, 32'd0);
        check({tag, "_perf_wait"}, perf_wait_cycles, 32'd0);
`endif
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("quiet_cfg", 32'(bus.mc_inst_config | bus.mc_lsb_config), 32'd0);
            check("quiet_done", 32'(bus.if_done | bus.lsb_done), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Wait (bounded) for the config pulse; returns at the drive point of the first WAIT cycle.
    task automatic await_grant(input bit exp_lsb, output bit ok, output int k_seen);
        bit seen, got_lsb, both;
        seen = 1'b0; got_lsb = 1'b0; both = 1'b0; k_seen = -1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            check("stray_done", 32'(bus.if_done | bus.lsb_done), 32'd0);
            if (bus.mc_inst_config || bus.mc_lsb_config) begin
                seen    = 1'b1;
                k_seen  = k;
                got_lsb = bus.mc_lsb_config;
                both    = bus.mc_inst_config && bus.mc_lsb_config;
                if (exp_lsb) begin
                    check("mc_lsb_ls",      32'(bus.mc_lsb_ls), 32'(m_ls));
                    check("mc_lsb_addr",    bus.mc_lsb_addr, m_addr);
                    check("mc_lsb_wdata",   bus.mc_lsb_wdata, m_wdata);
                    check("mc_lsb_precise", 32'(bus.mc_lsb_precise), 32'(m_prec));
                    check("mc_lsb_rob",     32'(bus.mc_lsb_rob), 32'(m_rob));
                end else begin
                    check("mc_inst_pc", bus.mc_inst_pc, m_pc & 32'hFFFF_FFC0);
                end
            end
            @(posedge clk); #1;
        end
        ok = seen;
        check("grant_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("grant_owner", 32'(got_lsb), 32'(exp_lsb));
            check("grant_onehot", 32'(both), 32'd0);
        end
    endtask

    // Run the WAIT phase from its first drive point, deliver mem_ctrl done, check the return.
    task automatic complete(input bit is_lsb, input int lat, input int rdy_low,
                            input bit rb_first, input bit drop);
        logic [31:0] rd;
        rd = $urandom;
        for (int i = 0; i < lat; i++) begin
            bus.rdy      = (i < rdy_low) ? 1'b0 : 1'b1;
            bus.rollback = rb_first && (i == 0);
            // Done for the non-owner must be ignored.
            if (is_lsb) bus.mc_inst_done = bus.rdy && ($urandom_range(0, 1) == 1);
            else        bus.mc_lsb_done  = bus.rdy && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            check("wait_cfg", 32'(bus.mc_inst_config | bus.mc_lsb_config), 32'd0);
            check("wait_done", 32'(bus.if_done | bus.lsb_done), 32'd0);
            if (is_lsb) check("hold_addr", bus.mc_lsb_addr, m_addr);
            else        check("hold_pc", bus.mc_inst_pc, m_pc & 32'hFFFF_FFC0);
            @(posedge clk); #1;
        end
        bus.rdy = 1'b1; bus.rollback = 1'b0;
        bus.mc_inst_done = !is_lsb;
        bus.mc_lsb_done  = is_lsb;
        bus.mc_lsb_data  = rd;
        @(negedge clk);
        check("pre_done", 32'(bus.if_done | bus.lsb_done), 32'd0);
        @(posedge clk); #1;
        bus.mc_inst_done = 1'b0;
        bus.mc_lsb_done  = 1'b0;
        if (drop) begin
            if (is_lsb) bus.lsb_req = 1'b0;
            else        bus.if_req  = 1'b0;
        end
        @(negedge clk);
        check("if_done",  32'(bus.if_done), 32'(!is_lsb));
        check("lsb_done", 32'(bus.lsb_done), 32'(is_lsb));
        if (is_lsb) begin
            check("lsb_rdata", bus.lsb_rdata, rd);
            check("lsb_done_rob", 32'(bus.lsb_done_rob), 32'(m_rob));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok, w, rb, if_pend, lsb_pend;
        int k, lat;
        int seq [7] = '{0, 0, 0, 0, 1, 0, 1};

        rst = 1'b1;
        bus.rdy = 1'b1; bus.rollback = 1'b0;
        bus.if_req = 1'b0; bus.if_pc = '0;
        bus.lsb_req = 1'b0; bus.lsb_ls = 1'b0; bus.lsb_addr = '0; bus.lsb_data = '0;
        bus.lsb_precise = '0; bus.lsb_rob = '0;
        bus.mc_inst_done = 1'b0; bus.mc_lsb_done = 1'b0; bus.mc_lsb_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Lone fetch.
        m_pc = 32'h0000_1040; bus.if_pc = m_pc; bus.if_req = 1'b1;
        w = grant_model(1'b1, 1'b0);
        await_grant(w, ok, k);
        if (ok) complete(1'b0, 2, 0, 1'b0, 1'b1);
        quiet(3);

        // Fetch and LSB both held: starvation guard.
        m_pc = 32'h0000_3000; bus.if_pc = m_pc; bus.if_req = 1'b1;
        set_lsb(1'b0, 32'h0000_0100, 32'h1122_3344, PREC_W, 4'd3);
        for (int i = 0; i < 7; i++) begin
            w = grant_model(bus.if_req, bus.lsb_req);
            await_grant(seq[i] == 1, ok, k);
            if (!ok) break;
            complete(seq[i] == 1, $urandom_range(0, 3), 0, 1'b0, (seq[i] == 1) || (i == 5));
            if (i == 4) set_lsb(1'b0, 32'h0000_0104, 32'h5566_7788, PREC_B, 4'd4);
        end

        // Load abandoned by rollback in WAIT, late done ignored, next grant after GAP.
        set_lsb(1'b1, 32'h0000_2000, 32'h0, PREC_W, 4'd5);
        w = grant_model(1'b0, 1'b1);
        await_grant(1'b1, ok, k);
        bus.rollback = 1'b1; bus.lsb_req = 1'b0;
        m_pc = 32'h0000_5A7C; bus.if_pc = m_pc; bus.if_req = 1'b1;
        @(negedge clk);
        check("rb_load_cfg", 32'(bus.mc_inst_config | bus.mc_lsb_config), 32'd0);
        @(posedge clk); #1;
        bus.rollback = 1'b0; bus.mc_lsb_done = 1'b1; bus.mc_lsb_data = 32'hBAD0_BAD0;
        @(negedge clk);
        check("rb_load_no_done", 32'(bus.lsb_done), 32'd0);
        @(posedge clk); #1;
        bus.mc_lsb_done = 1'b0;
        w = grant_model(1'b1, 1'b0);
        await_grant(1'b0, ok, k);
        check("rb_load_regrant", 32'(k), 32'd1);
        if (ok) complete(1'b0, 1, 0, 1'b1, 1'b1);

        // Rollback in IDLE blocks that cycle's grant; store survives rollback in WAIT.
        set_lsb(1'b0, 32'h0000_3000, 32'hDEAD_BEEF, PREC_W, 4'd9);
        bus.rollback = 1'b1;
        @(negedge clk);
        check("rb_idle_cfg", 32'(bus.mc_inst_config | bus.mc_lsb_config), 32'd0);
        @(posedge clk); #1;
        bus.rollback = 1'b0;
        w = grant_model(1'b0, 1'b1);
        await_grant(1'b1, ok, k);
        check("rb_idle_block", 32'(k), 32'd1);
        if (ok) complete(1'b1, 2, 0, 1'b1, 1'b1);

        // rdy low for 5 cycles during WAIT.
        set_lsb(1'b1, 32'h0000_4010, 32'h0, PREC_HS, 4'd12);
        w = grant_model(1'b0, 1'b1);
        await_grant(1'b1, ok, k);
        if (ok) complete(1'b1, 6, 5, 1'b0, 1'b1);

        // Reset during WAIT.
        m_pc = 32'h0000_7FC0; bus.if_pc = m_pc; bus.if_req = 1'b1;
        w = grant_model(1'b1, 1'b0);
        await_grant(1'b0, ok, k);
        rst = 1'b1; bus.if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        starve = 0; g_if = 0; g_lsb = 0;
        quiet(3);

        // Randomized traffic.
        if_pend = 1'b0; lsb_pend = 1'b0;
        for (int r = 0; r < 40; r++) begin
            if (!if_pend && ($urandom_range(0, 1) == 1)) begin
                m_pc = $urandom; bus.if_pc = m_pc; bus.if_req = 1'b1; if_pend = 1'b1;
            end
            if (!lsb_pend && (($urandom_range(0, 1) == 1) || !if_pend)) begin
                set_lsb(1'($urandom_range(0, 1)), $urandom, $urandom,
                        precs[$urandom_range(0, 4)], 4'($urandom_range(0, 15)));
                lsb_pend = 1'b1;
            end
            w = grant_model(if_pend, lsb_pend);
            await_grant(w, ok, k);
            if (!ok) break;
            rb  = !(w && m_ls) && ($urandom_range(0, 3) == 0);
            lat = $urandom_range(rb ? 1 : 0, 4);
            complete(w, lat, (lat > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, lat) : 0,
                     rb, 1'b1);
            if (w) lsb_pend = 1'b0;
            else   if_pend  = 1'b0;
        end

`ifdef ARB_PERF_EN
        check("perf_if_total",  perf_if_grants,  32'(g_if));
        check("perf_lsb_total", perf_lsb_grants, 32'(g_lsb));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
